// File: rtl/udp_vlg_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : udp_vlg_tx_arb
// Description : Multi-channel UDP transmit controller. Buffers N byte streams
//               in per-channel FIFOs, round-robin arbitrates between channels
//               that have a full datagram (or have gone idle), presents the
//               UDP/IPv4 header metadata and streams the payload bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_vlg_tx_arb #(
    parameter int N       = 2,
    parameter int MTU     = 1500,
    parameter int DEPTH   = 2048,
    parameter int TIMEOUT = 1000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [31:0]                          ipv4_addr,
    input  logic [N-1:0]                         in_val,
    input  logic [N-1:0][7:0]                    in_dat,
    output logic [N-1:0]                         in_cts,
    input  logic [N-1:0][15:0]                   loc_port,
    input  logic [N-1:0][15:0]                   rem_port,
    input  logic [N-1:0][31:0]                   rem_ipv4,
    input  logic [N-1:0][15:0]                   length,
    output logic                                 rdy,
    input  logic                                 req,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] chan,
    output logic [15:0]                          src_port,
    output logic [15:0]                          dst_port,
    output logic [15:0]                          udp_len,
    output logic [15:0]                          udp_cks,
    output logic [31:0]                          src_ip,
    output logic [31:0]                          dst_ip,
    output logic [15:0]                          ipv4_id,
    output logic [7:0]                           strm_dat,
    output logic                                 strm_val,
    output logic                                 strm_sof,
    output logic                                 strm_eof
);

    localparam int          c_CW          = (N > 1) ? $clog2(N) : 1;
    localparam int          c_AW          = $clog2(DEPTH);
    localparam int          c_IW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [31:0] c_MAX_PAYLOAD = 32'(MTU - 28);
    localparam logic [31:0] c_DEPTH32     = 32'(DEPTH);
    localparam logic [c_AW:0]   c_FULL    = DEPTH[c_AW:0];
    localparam logic [c_IW-1:0] c_TMO     = TIMEOUT[c_IW-1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_TX   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Per-channel views exported from the FIFO generate block
    logic [c_AW:0]   w_chan_cnt [N];
    logic [7:0]      w_chan_dat [N];
    logic [15:0]     w_chan_tgt [N];
    logic [N-1:0]    w_elig;

    // Arbiter / control
    logic            w_found;
    logic [c_CW-1:0] w_pick;
    logic [c_CW-1:0] w_idx;
    logic [15:0]     w_p;
    logic            w_sel;
    logic            w_pop;
    logic            w_first;
    logic            w_last;
    logic            w_done;

    // Datagram bookkeeping
    logic [c_CW-1:0] r_last;
    logic [15:0]     r_id_ctr;
    logic [15:0]     r_plen;
    logic [15:0]     r_rem;

    // Read stage between FIFO and stream outputs
    logic            r_pv;
    logic [7:0]      r_pd;
    logic            r_psof;
    logic            r_peof;

    // ------------------------------------------------------------------------
    // Per-channel FIFO, idle timer and eligibility
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        logic [7:0]      r_mem [DEPTH];
        logic [c_AW-1:0] r_wptr;
        logic [c_AW-1:0] r_rptr;
        logic [c_AW:0]   r_cnt;
        logic [c_AW:0]   w_cnt_nxt;
        logic [c_IW-1:0] r_idle;
        logic [31:0]     w_len_eff;
        logic [31:0]     w_t32;
        logic            w_wr;
        logic            w_rd;

        assign in_cts[gi]     = (r_cnt != c_FULL) && !rst;
        assign w_wr           = in_val[gi] && in_cts[gi];
        assign w_rd           = w_pop && (chan == c_CW'(gi));
        assign w_chan_cnt[gi] = r_cnt;
        assign w_chan_dat[gi] = r_mem[r_rptr];
        assign w_chan_tgt[gi] = w_t32[15:0];
        assign w_elig[gi]     = (32'(r_cnt) >= w_t32) ||
                                ((TIMEOUT != 0) && (r_cnt != '0) && (r_idle == c_TMO));

        // Target payload: requested length (0 = max), clipped to MTU and FIFO size
        always_comb begin
            w_len_eff = (length[gi] == 16'd0) ? c_MAX_PAYLOAD : {16'd0, length[gi]};
            w_t32     = w_len_eff;
            if (w_t32 > c_MAX_PAYLOAD) w_t32 = c_MAX_PAYLOAD;
            if (w_t32 > c_DEPTH32)     w_t32 = c_DEPTH32;
        end

        // Occupancy after this cycle's write/read; simultaneous ops cancel
        always_comb begin
            w_cnt_nxt = r_cnt;
            if (w_wr && !w_rd)      w_cnt_nxt = r_cnt + (c_AW+1)'(1);
            else if (!w_wr && w_rd) w_cnt_nxt = r_cnt - (c_AW+1)'(1);
        end

        // Payload storage; contents need no reset since pointers define validity
        always_ff @(posedge clk) begin
            if (w_wr) r_mem[r_wptr] <= in_dat[gi];
        end

        // Pointers, occupancy and idle timer (held at 0 while empty)
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
                r_idle <= '0;
            end else begin
                if (w_wr) r_wptr <= r_wptr + c_AW'(1);
                if (w_rd) r_rptr <= r_rptr + c_AW'(1);
                r_cnt <= w_cnt_nxt;
                if (w_wr || (w_cnt_nxt == '0))
                    r_idle <= '0;
                else if (r_idle != c_TMO)
                    r_idle <= r_idle + c_IW'(1);
            end
        end
    end

    // Round-robin search starting at the channel after the last one served
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = c_CW'((int'(r_last) + k) % N);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Payload of the datagram being launched: what is buffered, up to target
    assign w_p = (32'(w_chan_cnt[w_pick]) < 32'(w_chan_tgt[w_pick])) ?
                 16'(w_chan_cnt[w_pick]) : w_chan_tgt[w_pick];

    assign rdy     = (r_state == S_PEND);
    assign udp_cks = 16'h0000;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_sel       = 1'b0;
        w_pop       = 1'b0;
        w_first     = 1'b0;
        w_last      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_sel       = 1'b1;
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (req) begin
                    w_pop       = 1'b1;
                    w_first     = 1'b1;
                    w_last      = (r_plen == 16'd1);
                    w_state_nxt = S_TX;
                end
            end
            S_TX: begin
                if (r_rem != 16'd0) begin
                    w_pop  = 1'b1;
                    w_last = (r_rem == 16'd1);
                end else if (strm_eof) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Metadata latch on selection, byte countdown, read stage and stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            chan     <= '0;
            src_port <= '0;
            dst_port <= '0;
            udp_len  <= '0;
            src_ip   <= '0;
            dst_ip   <= '0;
            ipv4_id  <= '0;
            r_id_ctr <= '0;
            r_plen   <= '0;
            r_rem    <= '0;
            r_last   <= c_CW'(N - 1);
            r_pv     <= 1'b0;
            r_pd     <= '0;
            r_psof   <= 1'b0;
            r_peof   <= 1'b0;
            strm_val <= 1'b0;
            strm_dat <= '0;
            strm_sof <= 1'b0;
            strm_eof <= 1'b0;
        end else begin
            if (w_sel) begin
                chan     <= w_pick;
                src_port <= loc_port[w_pick];
                dst_port <= rem_port[w_pick];
                src_ip   <= ipv4_addr;
                dst_ip   <= rem_ipv4[w_pick];
                ipv4_id  <= r_id_ctr;
                r_id_ctr <= r_id_ctr + 16'd1;
                r_plen   <= w_p;
                udp_len  <= w_p + 16'd8;
            end
            if (w_pop) r_rem <= (w_first ? r_plen : r_rem) - 16'd1;
            if (w_done) r_last <= chan;
            r_pv     <= w_pop;
            r_pd     <= w_chan_dat[chan];
            r_psof   <= w_first;
            r_peof   <= w_last;
            strm_val <= r_pv;
            strm_dat <= r_pd;
            strm_sof <= r_psof;
            strm_eof <= r_peof;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_vlg_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_vlg_tx_arb
// Description : Self-checking bench for udp_vlg_tx_arb (N=2, TIMEOUT=16).
//               Written bytes are queued per channel and popped as the DUT
//               streams them out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_vlg_tx_arb;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       ipv4_addr;
    logic [1:0]        in_val;
    logic [1:0][7:0]   in_dat;
    logic [1:0]        in_cts;
    logic [1:0][15:0]  loc_port;
    logic [1:0][15:0]  rem_port;
    logic [1:0][31:0]  rem_ipv4;
    logic [1:0][15:0]  length;
    logic              rdy;
    logic              req;
    logic [0:0]        chan;
    logic [15:0]       src_port, dst_port, udp_len, udp_cks, ipv4_id;
    logic [31:0]       src_ip, dst_ip;
    logic [7:0]        strm_dat;
    logic              strm_val, strm_sof, strm_eof;

    int                vectors = 0;
    int                miscompares = 0;
    logic [15:0]       exp_id = 16'd0;
    logic [7:0]        q0 [$];
    logic [7:0]        q1 [$];

    udp_vlg_tx_arb #(.N(2), .MTU(1500), .DEPTH(2048), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .ipv4_addr(ipv4_addr),
        .in_val(in_val), .in_dat(in_dat), .in_cts(in_cts),
        .loc_port(loc_port), .rem_port(rem_port), .rem_ipv4(rem_ipv4),
        .length(length), .rdy(rdy), .req(req), .chan(chan),
        .src_port(src_port), .dst_port(dst_port), .udp_len(udp_len),
        .udp_cks(udp_cks), .src_ip(src_ip), .dst_ip(dst_ip),
        .ipv4_id(ipv4_id), .strm_dat(strm_dat), .strm_val(strm_val),
        .strm_sof(strm_sof), .strm_eof(strm_eof)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1);
    end

    function automatic int qsize(input logic c);
        return (c == 1'b0) ? q0.size() : q1.size();
    endfunction

    // Drive n consecutive bytes on channel c; model acceptance by occupancy
    task automatic write_bytes(input logic c, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            in_val[c] = 1'b1;
            in_dat[c] = base + 8'(i);
            if (qsize(c) < 2048) begin
                if (c == 1'b0) q0.push_back(base + 8'(i));
                else           q1.push_back(base + 8'(i));
            end
            @(negedge clk);
        end
        in_val[c] = 1'b0;
    endtask

    task automatic write_both(input int n, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < n; i++) begin
            in_val    = 2'b11;
            in_dat[0] = b0 + 8'(i);
            in_dat[1] = b1 + 8'(i);
            q0.push_back(b0 + 8'(i));
            q1.push_back(b1 + 8'(i));
            @(negedge clk);
        end
        in_val = 2'b00;
    endtask

    // Wait for a datagram, check header, request it and check every byte
    task automatic serve(input logic c, input int plen);
        int          t;
        logic [7:0]  b;
        logic [48:0] exp_meta;
        logic [95:0] exp_addr;
        logic [10:0] exp_b, got_b;
        t = 0;
        while (rdy !== 1'b1 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL rdy_wait: rdy=%b after %0d cycles, required 1", rdy, t);
            return;
        end
        exp_meta = {c, 16'(plen + 8), exp_id, 16'h0000};
        vectors++;
        if ({chan, udp_len, ipv4_id, udp_cks} !== exp_meta) begin
            miscompares++;
            $display("FAIL meta: chan/len/id/cks=%h, required %h",
                     {chan, udp_len, ipv4_id, udp_cks}, exp_meta);
        end
        exp_addr = {16'h1000 + {15'd0, c}, 16'h2000 + {15'd0, c},
                    32'hC0A8_0001, 32'h0A00_0000 + {31'd0, c}};
        vectors++;
        if ({src_port, dst_port, src_ip, dst_ip} !== exp_addr) begin
            miscompares++;
            $display("FAIL addr: ports/ips=%h, required %h",
                     {src_port, dst_port, src_ip, dst_ip}, exp_addr);
        end
        exp_id = exp_id + 16'd1;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        vectors++;
        if ({rdy, strm_val} !== 2'b00) begin
            miscompares++;
            $display("FAIL req_latency: rdy,strm_val=%b, required 00", {rdy, strm_val});
        end
        for (int i = 0; i < plen; i++) begin
            @(negedge clk);
            b = 8'hxx;
            if (qsize(c) > 0) b = (c == 1'b0) ? q0.pop_front() : q1.pop_front();
            exp_b = {1'b1, (i == 0), (i == plen - 1), b};
            got_b = {strm_val, strm_sof, strm_eof, strm_dat};
            vectors++;
            if (got_b !== exp_b) begin
                miscompares++;
                $display("FAIL byte%0d: val/sof/eof/dat=%h, required %h", i, got_b, exp_b);
            end
        end
        @(negedge clk);
        vectors++;
        if (strm_val !== 1'b0) begin
            miscompares++;
            $display("FAIL after_eof: strm_val=%b, required 0", strm_val);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (in_cts !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_cts: in_cts=%b, required 00", in_cts);
        end
        vectors++;
        if ({rdy, strm_val, strm_sof, strm_eof, chan, ipv4_id, udp_len,
             src_port, dst_port, src_ip, dst_ip} !== '0) begin
            miscompares++;
            $display("FAIL reset_out: rdy=%b val=%b chan=%h id=%h len=%h sp=%h dp=%h, required all 0",
                     rdy, strm_val, chan, ipv4_id, udp_len, src_port, dst_port);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_cts !== 2'b11) begin
            miscompares++;
            $display("FAIL release_cts: in_cts=%b, required 11", in_cts);
        end
    endtask

    task automatic test_basic;
        length[0] = 16'd4;
        length[1] = 16'd100;
        write_bytes(1'b0, 4, 8'h11);
        serve(1'b0, 4);
    endtask

    task automatic test_round_robin;
        length[0] = 16'd2;
        length[1] = 16'd2;
        write_both(2, 8'h21, 8'h31);
        serve(1'b1, 2);
        serve(1'b0, 2);
        write_bytes(1'b1, 2, 8'h41);
        serve(1'b1, 2);
        write_both(2, 8'h51, 8'h61);
        serve(1'b0, 2);
        serve(1'b1, 2);
    endtask

    task automatic test_timeout;
        int cnt;
        length[0] = 16'd100;
        length[1] = 16'd100;
        write_bytes(1'b0, 3, 8'h71);
        cnt = 0;
        while (rdy !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        vectors++;
        if (cnt != 17) begin
            miscompares++;
            $display("FAIL timeout_delay: rdy after %0d cycles, required 17", cnt);
        end
        serve(1'b0, 3);
        write_bytes(1'b0, 1, 8'h80);
        serve(1'b0, 1);
    endtask

    task automatic test_max_payload;
        length[0] = 16'd0;
        write_bytes(1'b0, 1500, 8'h00);
        serve(1'b0, 1472);
        serve(1'b0, 28);
    endtask

    task automatic test_fill;
        logic exp_cts;
        length[0] = 16'd0;
        for (int i = 0; i < 2060; i++) begin
            exp_cts = (q0.size() < 2048);
            vectors++;
            if (in_cts[0] !== exp_cts) begin
                miscompares++;
                $display("FAIL fill_cts%0d: in_cts[0]=%b, required %b", i, in_cts[0], exp_cts);
            end
            in_val[0] = 1'b1;
            in_dat[0] = 8'(i * 7);
            if (exp_cts) q0.push_back(8'(i * 7));
            @(negedge clk);
        end
        in_val[0] = 1'b0;
        serve(1'b0, 1472);
        serve(1'b0, 576);
    endtask

    task automatic test_reset_mid;
        int t;
        length[0] = 16'd8;
        write_bytes(1'b0, 8, 8'h90);
        t = 0;
        while (rdy !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({strm_val, strm_dat} !== {1'b1, 8'h92}) begin
            miscompares++;
            $display("FAIL mid_byte3: val,dat=%h, required 192", {strm_val, strm_dat});
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({strm_val, rdy, in_cts} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset: val,rdy,cts=%b, required 0000", {strm_val, rdy, in_cts});
        end
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        exp_id = 16'd0;
        length[1] = 16'd2;
        write_bytes(1'b1, 2, 8'hA1);
        serve(1'b1, 2);
        t = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy === 1'b1) t++;
        end
        vectors++;
        if (t != 0) begin
            miscompares++;
            $display("FAIL stale_data: rdy high %0d cycles after reset flush, required 0", t);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = 1'b0;
        in_val    = 2'b00;
        in_dat    = '0;
        ipv4_addr = 32'hC0A8_0001;
        loc_port  = {16'h1001, 16'h1000};
        rem_port  = {16'h2001, 16'h2000};
        rem_ipv4  = {32'h0A00_0001, 32'h0A00_0000};
        length    = {16'd100, 16'd100};
        @(negedge clk);
        test_reset;
        test_basic;
        test_round_robin;
        test_timeout;
        test_max_payload;
        test_fill;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
